// File: rtl/memory_pkg.sv
`default_nettype none
// memory_pkg -- shared widths and arbiter state encoding for memory_arbiter.
// Rev 1.0
package memory_pkg;

   localparam int ADDR_W      = 16;
   localparam int DATA_W      = 256;
   localparam int GRANT_IDX_W = 3;
   localparam int WAIT_CNT_W  = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// rr_arbiter -- combinational round-robin pick starting after last_grant_i.
// Rev 1.0
module rr_arbiter
   import memory_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]     req_i,
   input  logic [GRANT_IDX_W-1:0] last_grant_i,
   output logic [NUM_REQ-1:0]     gnt_o,
   output logic [GRANT_IDX_W-1:0] gnt_idx_o
);

   int   cand;
   logic found;

   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      found     = 1'b0;
      cand      = 0;
      // Walk NUM_REQ slots beginning one past the previous winner.
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = (int'(last_grant_i) + k) % NUM_REQ;
         if (!found && req_i[cand]) begin
            found       = 1'b1;
            gnt_o[cand] = 1'b1;
            gnt_idx_o   = GRANT_IDX_W'(cand);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/memory_arbiter.sv
`default_nettype none
// memory_arbiter -- round-robin arbiter of NUM_REQ requesters onto one memory port.
// Rev 1.0
module memory_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int ADDR_W      = memory_pkg::ADDR_W,
   parameter int DATA_W      = memory_pkg::DATA_W,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic [NUM_REQ-1:0]                  rq_req,
   input  logic [NUM_REQ-1:0]                  rq_w_en,
   input  logic [NUM_REQ*ADDR_W-1:0]           rq_addr,
   input  logic [NUM_REQ*DATA_W-1:0]           rq_wdata,
   output logic [NUM_REQ-1:0]                  rq_ack,
   output logic [NUM_REQ-1:0]                  rq_err,
   output logic [DATA_W-1:0]                   rq_rdata,
   output logic [memory_pkg::GRANT_IDX_W-1:0]  grant_id,
   output logic                                busy,
   output logic                                mem_req,
   output logic                                mem_w_en,
   output logic [ADDR_W-1:0]                   mem_addr,
   input  logic                                mem_ack,
   inout  wire  [DATA_W-1:0]                   mem_data
);
   import memory_pkg::*;

   localparam logic [WAIT_CNT_W-1:0] TIMEOUT_LIM = WAIT_CNT_W'(TIMEOUT_CYC);

   arb_state_e             state_q, state_d;
   logic [GRANT_IDX_W-1:0] grant_id_q, grant_id_d;
   logic [GRANT_IDX_W-1:0] last_grant_q, last_grant_d;
   logic [NUM_REQ-1:0]     gnt_oh_q, gnt_oh_d;
   logic [NUM_REQ-1:0]     ack_q, ack_d;
   logic [NUM_REQ-1:0]     err_q, err_d;
   logic                   mem_req_q, mem_req_d;
   logic                   mem_w_en_q, mem_w_en_d;
   logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]      rdata_q, rdata_d;
   logic [WAIT_CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic [WAIT_CNT_W-1:0]  wait_cnt_inc;
   logic [NUM_REQ-1:0]     arb_gnt;
   logic [GRANT_IDX_W-1:0] arb_idx;

   rr_arbiter #(
      .NUM_REQ      (NUM_REQ)
   ) u_rr_arbiter (
      .req_i        (rq_req),
      .last_grant_i (last_grant_q),
      .gnt_o        (arb_gnt),
      .gnt_idx_o    (arb_idx)
   );

   assign wait_cnt_inc = wait_cnt_q + 1'b1;

   always_comb begin
      state_d      = state_q;
      grant_id_d   = grant_id_q;
      last_grant_d = last_grant_q;
      gnt_oh_d     = gnt_oh_q;
      ack_d        = '0;
      err_d        = '0;
      mem_req_d    = mem_req_q;
      mem_w_en_d   = mem_w_en_q;
      mem_addr_d   = mem_addr_q;
      rdata_d      = rdata_q;
      wait_cnt_d   = wait_cnt_q;
      case (state_q)
         IDLE: begin
            if (|rq_req) begin
               state_d      = GRANT;
               grant_id_d   = arb_idx;
               last_grant_d = arb_idx;
               gnt_oh_d     = arb_gnt;
               mem_req_d    = 1'b1;
               mem_w_en_d   = rq_w_en[arb_idx];
               mem_addr_d   = rq_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
               wait_cnt_d   = '0;
            end
         end
         GRANT: begin
            // An ack landing on the final wait cycle still counts as success.
            if (mem_ack) begin
               state_d   = RELEASE;
               mem_req_d = 1'b0;
               ack_d     = gnt_oh_q;
               if (!mem_w_en_q) begin
                  rdata_d = mem_data;
               end
            end else begin
               wait_cnt_d = wait_cnt_inc;
               if (wait_cnt_inc == TIMEOUT_LIM) begin
                  state_d   = RELEASE;
                  mem_req_d = 1'b0;
                  err_d     = gnt_oh_q;
               end
            end
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         grant_id_q   <= '0;
         last_grant_q <= GRANT_IDX_W'(NUM_REQ - 1);
         gnt_oh_q     <= '0;
         ack_q        <= '0;
         err_q        <= '0;
         mem_req_q    <= 1'b0;
         mem_w_en_q   <= 1'b0;
         mem_addr_q   <= '0;
         rdata_q      <= '0;
         wait_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         grant_id_q   <= grant_id_d;
         last_grant_q <= last_grant_d;
         gnt_oh_q     <= gnt_oh_d;
         ack_q        <= ack_d;
         err_q        <= err_d;
         mem_req_q    <= mem_req_d;
         mem_w_en_q   <= mem_w_en_d;
         mem_addr_q   <= mem_addr_d;
         rdata_q      <= rdata_d;
         wait_cnt_q   <= wait_cnt_d;
      end
   end

   // The bus is released in every state except a write grant, including reset.
   assign mem_data = (state_q == GRANT && mem_w_en_q)
                     ? rq_wdata[int'(grant_id_q)*DATA_W +: DATA_W]
                     : {DATA_W{1'bz}};

   assign rq_ack   = ack_q;
   assign rq_err   = err_q;
   assign rq_rdata = rdata_q;
   assign grant_id = grant_id_q;
   assign busy     = (state_q != IDLE);
   assign mem_req  = mem_req_q;
   assign mem_w_en = mem_w_en_q;
   assign mem_addr = mem_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// tb_memory_arbiter -- directed self-checking bench for memory_arbiter.
// Rev 1.0
module tb_memory_arbiter;

   localparam int NUM_REQ     = 4;
   localparam int ADDR_W      = 16;
   localparam int DATA_W      = 256;
   localparam int TIMEOUT_CYC = 8;
   localparam logic [DATA_W-1:0] PROBE  = {64{4'h5}};
   localparam logic [DATA_W-1:0] PAT_A5 = {32{8'hA5}};
   localparam logic [DATA_W-1:0] PAT_C3 = {32{8'hC3}};

   logic                        clk = 1'b0;
   logic                        reset_n;
   logic [NUM_REQ-1:0]          rq_req;
   logic [NUM_REQ-1:0]          rq_w_en;
   logic [NUM_REQ*ADDR_W-1:0]   rq_addr;
   logic [NUM_REQ*DATA_W-1:0]   rq_wdata;
   logic [NUM_REQ-1:0]          rq_ack;
   logic [NUM_REQ-1:0]          rq_err;
   logic [DATA_W-1:0]           rq_rdata;
   logic [2:0]                  grant_id;
   logic                        busy;
   logic                        mem_req;
   logic                        mem_w_en;
   logic [ADDR_W-1:0]           mem_addr;
   logic                        mem_ack;
   logic                        drv_en;
   logic [DATA_W-1:0]           drv_val;
   wire  [DATA_W-1:0]           mem_data;

   int n_vec = 0;
   int n_err = 0;

   // Memory-side driver: a recognisable probe pattern whenever the DUT should be off the bus.
   assign mem_data = drv_en ? drv_val : {DATA_W{1'bz}};

   always #5 clk = ~clk;

   memory_arbiter #(
      .NUM_REQ     (NUM_REQ),
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .rq_req   (rq_req),
      .rq_w_en  (rq_w_en),
      .rq_addr  (rq_addr),
      .rq_wdata (rq_wdata),
      .rq_ack   (rq_ack),
      .rq_err   (rq_err),
      .rq_rdata (rq_rdata),
      .grant_id (grant_id),
      .busy     (busy),
      .mem_req  (mem_req),
      .mem_w_en (mem_w_en),
      .mem_addr (mem_addr),
      .mem_ack  (mem_ack),
      .mem_data (mem_data)
   );

   task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rq(input int i, input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      rq_w_en[i]                 = w;
      rq_addr[i*ADDR_W +: ADDR_W] = a;
      rq_wdata[i*DATA_W +: DATA_W] = d;
   endtask

   initial begin
      logic [DATA_W-1:0] exp_rdata;
      logic [3:0]        nib;
      logic [3:0]        oh;
      int                exp_id;
      int                n;

      rq_req = '0; rq_w_en = '0; rq_addr = '0; rq_wdata = '0;
      mem_ack = 1'b0; drv_en = 1'b1; drv_val = PROBE; reset_n = 1'b0;
      repeat (2) tick();
      chk("rst_mem_req",  mem_req,  0);
      chk("rst_mem_w_en", mem_w_en, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_rq_ack",   rq_ack,   0);
      chk("rst_rq_err",   rq_err,   0);
      chk("rst_rdata",    rq_rdata, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_busy",     busy,     0);
      chk("rst_bus_free", mem_data, PROBE);

      reset_n = 1'b1;
      tick();
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("stray_ack_busy", busy,   0);
      chk("stray_ack_ack",  rq_ack, 0);

      // Single read from requester 1
      set_rq(1, 1'b0, 16'h0040, '0);
      rq_req = 4'b0010;
      tick();
      chk("rd_mem_req",  mem_req,  1);
      chk("rd_mem_addr", mem_addr, 16'h0040);
      chk("rd_mem_w_en", mem_w_en, 0);
      chk("rd_grant_id", grant_id, 1);
      chk("rd_busy",     busy,     1);
      tick();
      tick();
      chk("rd_hold_req",  mem_req,  1);
      chk("rd_hold_addr", mem_addr, 16'h0040);
      mem_ack = 1'b1; drv_val = PAT_A5;
      tick();
      mem_ack = 1'b0; drv_val = PROBE; rq_req = '0;
      exp_rdata = PAT_A5;
      chk("rd_ack",     rq_ack,   4'b0010);
      chk("rd_err",     rq_err,   0);
      chk("rd_rdata",   rq_rdata, exp_rdata);
      chk("rd_rel_req", mem_req,  0);
      tick();
      chk("rd_ack_one", rq_ack, 0);
      chk("rd_idle",    busy,   0);

      // Single write from requester 2
      set_rq(2, 1'b1, 16'h0100, 256'h1234);
      rq_req = 4'b0100;
      chk("wr_idle_bus", mem_data, PROBE);
      drv_en = 1'b0;
      tick();
      chk("wr_grant_id", grant_id, 2);
      chk("wr_mem_w_en", mem_w_en, 1);
      chk("wr_mem_addr", mem_addr, 16'h0100);
      chk("wr_bus",      mem_data, 256'h1234);
      tick();
      chk("wr_bus_hold", mem_data, 256'h1234);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0; drv_en = 1'b1; rq_req = '0;
      #1;
      chk("wr_ack",      rq_ack,   4'b0100);
      chk("wr_rel_bus",  mem_data, PROBE);
      chk("wr_rdata",    rq_rdata, exp_rdata);
      tick();
      chk("wr_ack_one",  rq_ack,   0);

      // Fairness: all requesters asserted straight out of reset
      reset_n = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) set_rq(i, 1'b0, 16'h0200 + 16'(i), '0);
      rq_req = 4'hF;
      repeat (2) tick();
      reset_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         exp_id = k % NUM_REQ;
         oh     = 4'b0001 << exp_id;
         tick();
         chk("fair_grant", grant_id, 3'(exp_id));
         chk("fair_addr",  mem_addr, 16'h0200 + 16'(exp_id));
         nib = 4'(k + 1);
         mem_ack = 1'b1; drv_val = {64{nib}};
         exp_rdata = {64{nib}};
         tick();
         mem_ack = 1'b0; drv_val = PROBE;
         chk("fair_ack",   rq_ack,   oh);
         chk("fair_rdata", rq_rdata, exp_rdata);
         tick();
      end
      rq_req = '0;

      // Timeout: requester 3, memory silent
      rq_req = 4'b1000;
      tick();
      n = 0;
      for (int c = 0; c < 40 && mem_req; c++) begin
         n++;
         tick();
      end
      chk("to_len",   n,        TIMEOUT_CYC);
      chk("to_err",   rq_err,   4'b1000);
      chk("to_noack", rq_ack,   0);
      chk("to_busy",  busy,     1);
      chk("to_rdata", rq_rdata, exp_rdata);
      rq_req = '0;
      tick();
      chk("to_idle",  busy,     0);
      chk("to_err1",  rq_err,   0);

      // Ack on the last permitted wait cycle
      rq_req = 4'b0010;
      tick();
      chk("col_grant", grant_id, 1);
      repeat (TIMEOUT_CYC - 1) tick();
      chk("col_pre_req", mem_req, 1);
      mem_ack = 1'b1; drv_val = PAT_C3;
      tick();
      mem_ack = 1'b0; drv_val = PROBE; rq_req = '0;
      chk("col_ack",   rq_ack,   4'b0010);
      chk("col_noerr", rq_err,   0);
      chk("col_rdata", rq_rdata, PAT_C3);
      tick();

      // Reset during a write grant
      set_rq(2, 1'b1, 16'h0300, 256'hBEEF);
      rq_req = 4'b0100;
      drv_en = 1'b0;
      tick();
      chk("mrst_grant", grant_id, 2);
      chk("mrst_bus",   mem_data, 256'hBEEF);
      #2;
      reset_n = 1'b0; drv_en = 1'b1;
      #1;
      chk("mrst_req",   mem_req,  0);
      chk("mrst_busy",  busy,     0);
      chk("mrst_free",  mem_data, PROBE);
      set_rq(0, 1'b0, 16'h0010, '0);
      rq_req = 4'b1101;
      repeat (2) tick();
      chk("mrst_noack", rq_ack, 0);
      chk("mrst_noerr", rq_err, 0);
      reset_n = 1'b1;
      tick();
      chk("post_grant", grant_id, 0);
      chk("post_addr",  mem_addr, 16'h0010);
      chk("post_noack", rq_ack,   0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 16, address width.
- DATA_W, 256, data width.
- TIMEOUT_CYC, 255, maximum cycles to wait for mem_ack (1..255).
REQ-002 One clock; reset is asynchronous and active-low; ports are clk and reset_n.
REQ-003 Ports, one per line: name, direction, width, meaning:
- clk, in, 1, clock.
- reset_n, in, 1, asynchronous active-low reset.
- rq_req, in, NUM_REQ, per-requester request.
- rq_w_en, in, NUM_REQ, per-requester write enable (1=write).
- rq_addr, in, NUM_REQ x ADDR_W, per-requester address.
- rq_wdata, in, NUM_REQ x DATA_W, per-requester write data.
- rq_ack, out, NUM_REQ, per-requester completion pulse.
- rq_err, out, NUM_REQ, per-requester timeout pulse.
- rq_rdata, out, DATA_W, read data, shared by all requesters.
- grant_id, out, 3, index of the current or last granted requester.
- busy, out, 1, high whenever state is not IDLE.
- mem_req, out, 1, memory request.
- mem_w_en, out, 1, memory write enable.
- mem_addr, out, ADDR_W, memory address.
- mem_ack, in, 1, memory acknowledge (one-cycle pulse).
- mem_data, inout, DATA_W, shared memory data bus.

Function
REQ-004 Requester handshake:
- Requester holds rq_req, rq_w_en, rq_addr and rq_wdata stable until it sees rq_ack or rq_err.
- It drops rq_req in the following cycle unless it is starting a new transaction.
REQ-005 FSM has three states: IDLE, GRANT, RELEASE.
- IDLE -> GRANT when any rq_req bit is high.
- GRANT -> RELEASE when mem_ack is high, or when the timeout fires.
- RELEASE -> IDLE unconditionally, after one cycle.
REQ-006 Arbitration is round-robin.
- Search starts at (last_grant+1) mod NUM_REQ; the first asserted rq_req wins.
- last_grant updates when GRANT is entered.
REQ-007 Latency:
- Request sampled in IDLE at edge t: mem_req, mem_addr, mem_w_en and grant_id are registered and valid from t+1.
- Best case is request to mem_req in 1 cycle, and mem_ack to rq_ack in 1 cycle.
REQ-008 mem_req stays high throughout GRANT and goes low in RELEASE.
- mem_addr and mem_w_en are held constant during GRANT.
REQ-009 Write data bus:
- mem_data is driven with rq_wdata[grant_id] only in GRANT with mem_w_en=1.
- In every other case mem_data is high-impedance.
REQ-010 Read completion: on mem_ack in GRANT with mem_w_en=0, mem_data is captured into rq_rdata.
- rq_rdata holds that value until the next read completes.
REQ-011 rq_ack[grant_id] pulses for exactly one cycle, during RELEASE, after mem_ack; all other rq_ack bits stay 0.
REQ-012 Timeout:
- A wait counter clears on entry to GRANT and increments each GRANT cycle that has no mem_ack.
- When the counter reaches TIMEOUT_CYC, rq_err[grant_id] pulses during RELEASE, with no rq_ack.
- rq_rdata is unchanged on timeout.
REQ-013 mem_ack in the same cycle as the timeout is treated as success: ack only, no err.
REQ-014 mem_ack sampled outside GRANT is ignored.
REQ-015 A requester whose rq_req is low in IDLE is never granted.
- A requester that drops rq_req while granted has no effect on the current transaction.
REQ-016 busy = (state != IDLE).

Reset
REQ-017 While reset_n=0, the following hold asynchronously:
- state=IDLE, mem_req=0, mem_w_en=0, mem_addr=0, mem_data high-impedance.
- rq_ack=0, rq_err=0, rq_rdata=0, grant_id=0, busy=0.
- last_grant=NUM_REQ-1, so requester 0 has first priority after reset.
- wait counter=0.
REQ-018 Reset asserted mid-transaction aborts it: no ack or err pulse is produced.
- The first grant after reset release follows REQ-017 priority.

Structure
REQ-019 Shared package memory_pkg holds:
- ADDR_W=16 and DATA_W=256;
- the arbiter state enum (IDLE, GRANT, RELEASE);
- the grant-index width.
REQ-020 One sub-module, rr_arbiter, is combinational: inputs are the request vector and last_grant; outputs are the one-hot grant and the grant index.
- The FSM, counter and data bus logic stay in memory_arbiter.

Verification
REQ-021 Single read:
- Stimulus: rq_req[1]=1, addr 16'h0040, w_en=0; memory acks 3 cycles after mem_req with data 256'hA5..A5.
- Response: mem_addr=16'h0040; rq_ack[1] pulses once; rq_rdata=256'hA5..A5.
REQ-022 Single write:
- Stimulus: rq_req[2]=1, addr 16'h0100, wdata 256'h1234.
- Response: mem_data=256'h1234 only while in GRANT, high-impedance otherwise; rq_ack[2] pulses once.
REQ-023 Fairness:
- Stimulus: all 4 requests held continuously from reset.
- Response: grant order 0,1,2,3,0; no requester is granted twice before all others have been granted.
REQ-024 Timeout:
- Stimulus: TIMEOUT_CYC=8, memory never acks.
- Response: mem_req drops after 8 GRANT cycles; rq_err pulses; no rq_ack; busy returns to 0.
REQ-025 Ack-timeout collision:
- Stimulus: mem_ack arrives exactly in timeout cycle 8.
- Response: rq_ack pulses; rq_err stays 0.
REQ-026 Reset mid-operation:
- Stimulus: reset_n asserted during GRANT of a write.
- Response: mem_req=0 and mem_data high-impedance immediately; no ack; requester 0 is granted first after release.
